iddmm_core_arbiter: RTL and testbench
=====================================

# iddmm_core_arbiter

Parametrised N-client arbiter that time-shares one `mmp_iddmm_sp` Montgomery multiplier core among `NUM_CLIENTS` requesters, such as modular-exponentiation and modular-multiplication engines. It generalises the fixed two-client ME/MM select to a round-robin, lock-based scheme. A client owns the core across any number of back-to-back IDDMM tasks. Release is deferred until any in-flight task completes, and illegal accesses by non-owners are flagged. The block sits between the client engines and the single shared core, inside the Paillier top level.

## Interface
- `K`, 128, bits per operand word.
- `N`, 32, words per operand; address width is `AW = $clog2(N)`.
- `NUM_CLIENTS`, 4, number of requesters, legal range 2..16; `CW = $clog2(NUM_CLIENTS)`.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cl_lock_req`  in  NUM_CLIENTS  per-client request for core ownership; held high while the client wants the core.
- `cl_own`  out  NUM_CLIENTS  one-hot (or zero) ownership indication, registered.
- `cl_wr_ena`  in  3*NUM_CLIENTS  per-client x/y/m write enables.
- `cl_wr_addr`  in  AW*NUM_CLIENTS  per-client write word address.
- `cl_wr_x`, `cl_wr_y`, `cl_wr_m`, `cl_wr_m1`  in  K*NUM_CLIENTS each  per-client write data, low words first.
- `cl_task_req`  in  NUM_CLIENTS  per-client task request.
- `cl_task_grant`, `cl_task_end`  out  NUM_CLIENTS  routed core handshakes; zero for non-owners.
- `cl_task_res`  out  K  core result, driven only while the owner is active; zero otherwise.
- `core_wr_ena`  out  3  write enables to the core.
- `core_wr_addr`  out  AW  write address to the core.
- `core_wr_x`, `core_wr_y`, `core_wr_m`, `core_wr_m1`  out  K each  write data to the core.
- `core_task_req`  out  1  task request to the core.
- `core_task_grant`, `core_task_end`  in  1  core handshakes.
- `core_task_res`  in  K  core result.
- `owner_id`  out  CW  current or last owner index.
- `busy`  out  1  high in OWNED or DRAIN.
- `err_illegal`  out  1  sticky protocol-violation flag.

## Operation
- States:
  - IDLE: no owner.
  - OWNED: one client holds the core.
  - DRAIN: the owner has released, but a task is still in flight.
- Round-robin pointer `rr_ptr`:
  - In IDLE, the arbiter searches for the first asserted `cl_lock_req` starting at `rr_ptr+1` (mod NUM_CLIENTS).
  - On a hit it registers `owner_id` and moves to OWNED.
  - `rr_ptr` takes the value of `owner_id` when ownership ends, so the next search starts after the previous owner.
- Forwarding in OWNED (combinational, same cycle):
  - The owner's `wr_*` and `task_req` drive the `core_*` outputs.
  - `core_task_grant`, `core_task_end` and `core_task_res` route back to the owner only.
- Forwarding in IDLE and DRAIN:
  - `core_wr_ena`=0, `core_task_req`=0, and all `core_*` data outputs are 0.
  - In DRAIN, `core_task_end` and `core_task_res` still route to `owner_id`.
- `task_active` flag:
  - Set on `core_task_grant`.
  - Cleared on `core_task_end`.
- Release from OWNED when the owner's `cl_lock_req` is low:
  - If `task_active`=0, go to IDLE.
  - If `task_active`=1, go to DRAIN.
- DRAIN exits to IDLE on `core_task_end`.
- `err_illegal` is set when any non-owner asserts `cl_wr_ena` or `cl_task_req`, or when any client asserts them in IDLE or DRAIN. It is cleared only by reset.
- Illegal inputs are never forwarded to the core.

## Timing
- Reset values:
  - State IDLE; `rr_ptr` = NUM_CLIENTS-1, so client 0 wins first.
  - `owner_id`=0, `cl_own`=0, `busy`=0, `err_illegal`=0, `task_active`=0.
  - All `cl_task_*` and `core_*` outputs are 0.
- Acquire latency: `cl_lock_req` high in cycle t (IDLE) gives `cl_own[i]`=1 and `busy`=1 in t+1. The first write may be issued in t+1.
- Release latency: lock dropped in cycle t with no task in flight gives `cl_own`=0 in t+1. The next owner is granted in t+2 at the earliest, because IDLE always lasts at least one cycle.
- When the lock is dropped during a task, `cl_own` goes low in t+1. `busy` stays high until the cycle after `core_task_end`.
- If a new request and the owner's release occur in the same cycle, the new request is evaluated only from IDLE.
- If all clients request simultaneously, the order is strictly round-robin.
- Reset mid-task: the state returns to IDLE immediately. The core is assumed to be reset by the same `rst_n`.

## Structure
- Shared package `iddmm_pkg`:
  - `iddmm_arb_state_e` enum (IDLE/OWNED/DRAIN).
  - Width localparams (`AW`, `CW`).
  - Write-enable bit indices (`WR_X`=0, `WR_Y`=1, `WR_M`=2).
- One natural sub-module, `rr_pick`: a combinational round-robin priority encoder (req vector, ptr) -> (hit, index).
- The FSM, flags and muxing live in the top.

## Test plan
- Single client 2 asserts lock at cycle 10 -> `cl_own`=4'b0100 at cycle 11. Two tasks complete with `cl_task_end[2]` pulsing twice; `core_task_res` equals `cl_task_res`.
- All four clients hold lock continuously, each releasing after one task -> owners granted in order 0,1,2,3,0, with ≥1 IDLE cycle between owners.
- Owner 1 drops lock one cycle after `core_task_grant` -> state DRAIN, `cl_own`=0, `busy`=1. `cl_task_end[1]` still pulses with the result, then IDLE.
- Client 3 writes `cl_wr_ena`=3'b001 while client 0 owns -> `core_wr_ena` unaffected and `err_illegal`=1 from the next cycle, persisting until reset.
- Assert `rst_n`=0 during OWNED with a task active -> next edge all outputs are 0 and the state is IDLE. The first grant after reset goes to client 0 when clients 0 and 2 request together.

Source files
------------

// File: rtl/iddmm_core_arbiter_pkg.sv
// Shared definitions for the IDDMM core arbiter: state encoding, default
// geometry and the per-client write-enable bit layout.
package iddmm_pkg;

  localparam int IDDMM_K           = 128;
  localparam int IDDMM_N           = 32;
  localparam int IDDMM_NUM_CLIENTS = 4;

  localparam int AW = $clog2(IDDMM_N);
  localparam int CW = $clog2(IDDMM_NUM_CLIENTS);

  // Bit positions inside each client's 3-bit write-enable group.
  localparam int WR_X    = 0;
  localparam int WR_Y    = 1;
  localparam int WR_M    = 2;
  localparam int WR_BITS = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWNED = 2'd1,
    DRAIN = 2'd2
  } iddmm_arb_state_e;

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iddmm_core_arbiter_rr_pick.sv
// Round-robin priority encoder: finds the first set request bit starting
// one position after ptr, wrapping modulo NUM_CLIENTS.
module rr_pick
  import iddmm_pkg::*;
#(
  parameter int NUM_CLIENTS = IDDMM_NUM_CLIENTS,
  parameter int IDX_W       = idx_width(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic                   hit,
  output logic [IDX_W-1:0]       idx
);

  // Scan ptr+1, ptr+2, ... ptr+NUM_CLIENTS and keep the first hit.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    hit = 1'b0;
    idx = '0;
    for (int off = 1; off <= NUM_CLIENTS; off++) begin
      if (!hit && req[(int'(ptr) + off) % NUM_CLIENTS]) begin
        hit = 1'b1;
        idx = IDX_W'((int'(ptr) + off) % NUM_CLIENTS);
      end
    end
  end

endmodule

// File: rtl/iddmm_core_arbiter.sv
// Lock-based round-robin arbiter that time-shares one IDDMM Montgomery core
// among NUM_CLIENTS engines. The owner keeps the core across any number of
// tasks; release waits for an in-flight task; non-owner activity is blocked
// and flagged.
module iddmm_core_arbiter
  import iddmm_pkg::*;
#(
  parameter  int K           = IDDMM_K,
  parameter  int N           = IDDMM_N,
  parameter  int NUM_CLIENTS = IDDMM_NUM_CLIENTS,
  localparam int ADDR_W      = idx_width(N),
  localparam int IDX_W       = idx_width(NUM_CLIENTS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CLIENTS-1:0]        cl_lock_req,
  output logic [NUM_CLIENTS-1:0]        cl_own,
  input  logic [WR_BITS*NUM_CLIENTS-1:0] cl_wr_ena,
  input  logic [ADDR_W*NUM_CLIENTS-1:0] cl_wr_addr,
  input  logic [K*NUM_CLIENTS-1:0]      cl_wr_x,
  input  logic [K*NUM_CLIENTS-1:0]      cl_wr_y,
  input  logic [K*NUM_CLIENTS-1:0]      cl_wr_m,
  input  logic [K*NUM_CLIENTS-1:0]      cl_wr_m1,
  input  logic [NUM_CLIENTS-1:0]        cl_task_req,
  output logic [NUM_CLIENTS-1:0]        cl_task_grant,
  output logic [NUM_CLIENTS-1:0]        cl_task_end,
  output logic [K-1:0]                  cl_task_res,
  output logic [WR_BITS-1:0]            core_wr_ena,
  output logic [ADDR_W-1:0]             core_wr_addr,
  output logic [K-1:0]                  core_wr_x,
  output logic [K-1:0]                  core_wr_y,
  output logic [K-1:0]                  core_wr_m,
  output logic [K-1:0]                  core_wr_m1,
  output logic                          core_task_req,
  input  logic                          core_task_grant,
  input  logic                          core_task_end,
  input  logic [K-1:0]                  core_task_res,
  output logic [IDX_W-1:0]              owner_id,
  output logic                          busy,
  output logic                          err_illegal
);

  iddmm_arb_state_e       state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_hit;
  logic                   task_active;
  logic                   task_active_nxt;
  logic [NUM_CLIENTS-1:0] owner_mask;
  logic [NUM_CLIENTS-1:0] client_act;

  rr_pick #(
    .NUM_CLIENTS(NUM_CLIENTS),
    .IDX_W      (IDX_W)
  ) u_rr_pick (
    .req(cl_lock_req),
    .ptr(rr_ptr),
    .hit(pick_hit),
    .idx(pick_idx)
  );

  // Decode owner and collect per-client write/task activity.
  always_comb begin
    owner_mask = NUM_CLIENTS'(1) << owner_id;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      client_act[i] = (|cl_wr_ena[i*WR_BITS +: WR_BITS]) | cl_task_req[i];
    end
  end

  // A grant in this cycle starts a task even if the matching end is for an
  // older one, so grant takes priority over end.
  always_comb begin
    if (core_task_grant)    task_active_nxt = 1'b1;
    else if (core_task_end) task_active_nxt = 1'b0;
    else                    task_active_nxt = task_active;
  end

  // Ownership FSM with registered owner, ownership vector and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= IDX_W'(NUM_CLIENTS - 1);
      owner_id    <= '0;
      cl_own      <= '0;
      task_active <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      task_active <= task_active_nxt;
      // cl_own is one-hot only in OWNED, so this covers both non-owners and
      // any activity while nobody owns the core.
      if (|(client_act & ~cl_own)) err_illegal <= 1'b1;
      case (state)
        IDLE: begin
          if (pick_hit) begin
            owner_id <= pick_idx;
            cl_own   <= NUM_CLIENTS'(1) << pick_idx;
            state    <= OWNED;
          end
        end
        OWNED: begin
          if (!cl_lock_req[owner_id]) begin
            cl_own <= '0;
            rr_ptr <= owner_id;
            state  <= task_active_nxt ? DRAIN : IDLE;
          end
        end
        DRAIN: begin
          if (core_task_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // Route the owner's traffic to the core and the core's responses back.
  always_comb begin
    core_wr_ena   = '0;
    core_wr_addr  = '0;
    core_wr_x     = '0;
    core_wr_y     = '0;
    core_wr_m     = '0;
    core_wr_m1    = '0;
    core_task_req = 1'b0;
    cl_task_grant = '0;
    cl_task_end   = '0;
    cl_task_res   = '0;
    if (state == OWNED) begin
      core_wr_ena   = cl_wr_ena[int'(owner_id)*WR_BITS +: WR_BITS];
      core_wr_addr  = cl_wr_addr[int'(owner_id)*ADDR_W +: ADDR_W];
      core_wr_x     = cl_wr_x[int'(owner_id)*K +: K];
      core_wr_y     = cl_wr_y[int'(owner_id)*K +: K];
      core_wr_m     = cl_wr_m[int'(owner_id)*K +: K];
      core_wr_m1    = cl_wr_m1[int'(owner_id)*K +: K];
      core_task_req = cl_task_req[owner_id];
      cl_task_grant = owner_mask & {NUM_CLIENTS{core_task_grant}};
    end
    if (state == OWNED || state == DRAIN) begin
      cl_task_end = owner_mask & {NUM_CLIENTS{core_task_end}};
      cl_task_res = core_task_res;
    end
  end

endmodule

// File: tb/tb_iddmm_core_arbiter.sv
// Randomised scoreboard bench for iddmm_core_arbiter with a behavioural
// IDDMM core model and a round-robin ownership reference.
module tb_iddmm_core_arbiter;
  import iddmm_pkg::*;

  localparam int K  = 128;
  localparam int N  = 32;
  localparam int NC = 4;
  localparam int AWT = 5;
  localparam int CWT = 2;

  typedef struct {
    logic [2:0]     ena;
    logic [AWT-1:0] addr;
    logic [K-1:0]   x, y, m, m1;
  } wr_t;

  typedef struct {
    int           client;
    logic [K-1:0] res;
  } task_exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC-1:0]     cl_lock_req;
  logic [NC-1:0]     cl_own;
  logic [3*NC-1:0]   cl_wr_ena;
  logic [AWT*NC-1:0] cl_wr_addr;
  logic [K*NC-1:0]   cl_wr_x, cl_wr_y, cl_wr_m, cl_wr_m1;
  logic [NC-1:0]     cl_task_req, cl_task_grant, cl_task_end;
  logic [K-1:0]      cl_task_res;
  logic [2:0]        core_wr_ena;
  logic [AWT-1:0]    core_wr_addr;
  logic [K-1:0]      core_wr_x, core_wr_y, core_wr_m, core_wr_m1;
  logic              core_task_req;
  logic              core_task_grant, core_task_end;
  logic [K-1:0]      core_task_res;
  logic [CWT-1:0]    owner_id;
  logic              busy, err_illegal;

  int n_checks = 0;
  int n_errors = 0;

  wr_t          exp_wr_q[$];
  task_exp_t    exp_task_q[$];
  int           exp_own_q[$];
  logic [K-1:0] core_res_q[$];
  int           next_lat = 3;
  int           model_last = NC - 1;

  always #5 clk = ~clk;

  iddmm_core_arbiter #(.K(K), .N(N), .NUM_CLIENTS(NC)) dut (
    .clk(clk), .rst_n(rst_n),
    .cl_lock_req(cl_lock_req), .cl_own(cl_own),
    .cl_wr_ena(cl_wr_ena), .cl_wr_addr(cl_wr_addr),
    .cl_wr_x(cl_wr_x), .cl_wr_y(cl_wr_y), .cl_wr_m(cl_wr_m), .cl_wr_m1(cl_wr_m1),
    .cl_task_req(cl_task_req), .cl_task_grant(cl_task_grant),
    .cl_task_end(cl_task_end), .cl_task_res(cl_task_res),
    .core_wr_ena(core_wr_ena), .core_wr_addr(core_wr_addr),
    .core_wr_x(core_wr_x), .core_wr_y(core_wr_y), .core_wr_m(core_wr_m),
    .core_wr_m1(core_wr_m1), .core_task_req(core_task_req),
    .core_task_grant(core_task_grant), .core_task_end(core_task_end),
    .core_task_res(core_task_res),
    .owner_id(owner_id), .busy(busy), .err_illegal(err_illegal)
  );

  task automatic check(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ownership rule: first requester after the previous owner.
  function automatic int rr_next(input int last, input logic [NC-1:0] mask);
    for (int k = 1; k <= NC; k++) begin
      if (mask[(last + k) % NC]) return (last + k) % NC;
    end
    return 0;
  endfunction

  function automatic logic [K-1:0] rand_k();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Behavioural core: grants one cycle after a request, ends next_lat later.
  bit cbusy;
  int cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_task_grant <= 1'b0;
      core_task_end   <= 1'b0;
      core_task_res   <= '0;
      cbusy           <= 1'b0;
      cnt             <= 0;
    end else begin
      core_task_grant <= 1'b0;
      core_task_end   <= 1'b0;
      if (!cbusy && core_task_req) begin
        core_task_grant <= 1'b1;
        cbusy           <= 1'b1;
        cnt             <= next_lat;
      end else if (cbusy) begin
        if (cnt <= 1) begin
          core_task_end <= 1'b1;
          cbusy         <= 1'b0;
          if (core_res_q.size() > 0) core_task_res <= core_res_q.pop_front();
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  // Monitor: compares core writes, task completions and ownership changes.
  logic [NC-1:0] prev_own = '0;
  always @(negedge clk) begin
    wr_t       we;
    task_exp_t te;
    int        eo;
    if (!rst_n) begin
      prev_own = '0;
    end else begin
      if (core_wr_ena != 3'b000) begin
        if (exp_wr_q.size() == 0) check("unexpected_core_wr", 1, 0);
        else begin
          we = exp_wr_q.pop_front();
          check("wr_ena", core_wr_ena, we.ena);
          check("wr_addr", core_wr_addr, we.addr);
          check("wr_x", core_wr_x, we.x);
          check("wr_y", core_wr_y, we.y);
          check("wr_m", core_wr_m, we.m);
          check("wr_m1", core_wr_m1, we.m1);
        end
      end
      if (core_task_end || cl_task_end != '0) begin
        if (exp_task_q.size() == 0) check("unexpected_task_end", 1, 0);
        else begin
          te = exp_task_q.pop_front();
          check("task_end_route", cl_task_end, 1 << te.client);
          check("task_res", cl_task_res, te.res);
          check("task_res_passthru", cl_task_res, core_task_res);
        end
      end
      if (cl_own != prev_own) begin
        if (cl_own != '0) begin
          check("own_onehot", $onehot(cl_own), 1);
          check("own_idle_gap", prev_own == '0, 1);
          if (exp_own_q.size() == 0) check("unexpected_own", 1, 0);
          else begin
            eo = exp_own_q.pop_front();
            check("own_client", cl_own, 1 << eo);
          end
        end
        prev_own = cl_own;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_own(input int c);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cl_own[c]) return;
    end
    check("own_timeout", 0, 1);
  endtask

  task automatic acquire(input logic [NC-1:0] mask, output int e);
    e = rr_next(model_last, mask);
    exp_own_q.push_back(e);
    tick();
    cl_lock_req = mask;
    wait_own(e);
  endtask

  task automatic release_all(input int c);
    model_last = c;
    tick();
    cl_lock_req = '0;
    @(negedge clk);
    @(negedge clk);
    check("release_latency", cl_own, 0);
  endtask

  task automatic do_write(input int c);
    wr_t w;
    w.ena  = 3'($urandom_range(1, 7));
    w.addr = AWT'($urandom);
    w.x = rand_k(); w.y = rand_k(); w.m = rand_k(); w.m1 = rand_k();
    exp_wr_q.push_back(w);
    tick();
    cl_wr_ena[c*3 +: 3]      = w.ena;
    cl_wr_addr[c*AWT +: AWT] = w.addr;
    cl_wr_x[c*K +: K]  = w.x;
    cl_wr_y[c*K +: K]  = w.y;
    cl_wr_m[c*K +: K]  = w.m;
    cl_wr_m1[c*K +: K] = w.m1;
    tick();
    cl_wr_ena[c*3 +: 3] = 3'b000;
  endtask

  task automatic do_task(input int c, input int lat, input bit drop_lock);
    task_exp_t te;
    bit        seen;
    te.client = c;
    te.res    = rand_k();
    exp_task_q.push_back(te);
    core_res_q.push_back(te.res);
    next_lat = lat;
    tick();
    cl_task_req[c] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = cl_task_grant[c];
    end
    if (!seen) check("grant_timeout", 0, 1);
    tick();
    cl_task_req[c] = 1'b0;
    if (drop_lock) begin
      cl_lock_req[c] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("drain_own", cl_own, 0);
      check("drain_busy", busy, 1);
    end
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = core_task_end;
    end
    if (!seen) check("end_timeout", 0, 1);
    if (drop_lock) begin
      check("drain_busy_at_end", busy, 1);
      @(negedge clk);
      check("drain_exit_busy", busy, 0);
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    cl_lock_req = '0;
    cl_task_req = '0;
    cl_wr_ena   = '0;
    exp_task_q.delete();
    core_res_q.delete();
    model_last = NC - 1;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_own"}, cl_own, 0);
    check({tag, "_owner_id"}, owner_id, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err_illegal, 0);
    check({tag, "_core_wr_ena"}, core_wr_ena, 0);
    check({tag, "_core_task_req"}, core_task_req, 0);
    check({tag, "_core_wr_x"}, core_wr_x, 0);
    check({tag, "_cl_grant_end"}, {cl_task_grant, cl_task_end}, 0);
    check({tag, "_cl_res"}, cl_task_res, 0);
  endtask

  initial begin
    int  e;
    bit  seen;
    rst_n       = 1'b0;
    cl_lock_req = '0;
    cl_wr_ena   = '0;
    cl_wr_addr  = '0;
    cl_wr_x = '0; cl_wr_y = '0; cl_wr_m = '0; cl_wr_m1 = '0;
    cl_task_req = '0;

    // Reset state.
    tick();
    tick();
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    // Single client 2: acquire latency, two tasks with writes.
    exp_own_q.push_back(rr_next(model_last, 4'b0100));
    tick();
    cl_lock_req = 4'b0100;
    @(negedge clk);
    check("acq_not_yet", cl_own, 0);
    @(negedge clk);
    check("acq_own", cl_own, 4'b0100);
    check("acq_busy", busy, 1);
    check("acq_owner_id", owner_id, 2);
    do_write(2);
    do_task(2, 3, 1'b0);
    do_write(2);
    do_task(2, 2, 1'b0);
    release_all(2);

    // All four clients contend: strict round-robin 0,1,2,3,0.
    do_reset();
    e = rr_next(model_last, '1);
    exp_own_q.push_back(e);
    tick();
    cl_lock_req = '1;
    for (int k = 0; k < 5; k++) begin
      int owner;
      owner = e;
      wait_own(owner);
      do_task(owner, $urandom_range(1, 4), 1'b0);
      model_last = owner;
      if (k < 4) begin
        e = rr_next(model_last, '1);
        exp_own_q.push_back(e);
      end
      tick();
      if (k == 4) cl_lock_req = '0;
      else        cl_lock_req[owner] = 1'b0;
      tick();
      if (k < 4) cl_lock_req[owner] = 1'b1;
    end
    repeat (3) tick();

    // Owner 1 drops lock one cycle after grant: DRAIN path.
    acquire(4'b0010, e);
    do_task(e, 6, 1'b1);
    model_last = e;
    repeat (2) tick();

    // Client 3 writes while client 0 owns: blocked and flagged.
    check("err_before_illegal", err_illegal, 0);
    acquire(4'b0001, e);
    tick();
    cl_wr_ena[3*3 +: 3] = 3'b001;
    cl_wr_x[3*K +: K]   = rand_k();
    @(negedge clk);
    check("err_not_yet", err_illegal, 0);
    check("illegal_not_fwd", core_wr_ena, 0);
    tick();
    cl_wr_ena[3*3 +: 3] = 3'b000;
    @(negedge clk);
    check("err_set", err_illegal, 1);
    do_write(e);
    repeat (4) tick();
    check("err_sticky", err_illegal, 1);
    release_all(e);

    // Randomised ownership, write and task traffic.
    for (int it = 0; it < 12; it++) begin
      int nw, nt;
      acquire(NC'($urandom_range(1, 15)), e);
      nw = $urandom_range(0, 2);
      nt = $urandom_range(1, 2);
      for (int w = 0; w < nw; w++) do_write(e);
      for (int t = 0; t < nt; t++) do_task(e, $urandom_range(1, 5), 1'b0);
      release_all(e);
      tick();
    end
    check("err_still_sticky", err_illegal, 1);

    // Reset during an active task.
    acquire(4'b0001, e);
    core_res_q.push_back(rand_k());
    next_lat = 20;
    tick();
    cl_task_req[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = cl_task_grant[0];
    end
    if (!seen) check("mid_grant_timeout", 0, 1);
    tick();
    cl_task_req[0] = 1'b0;
    @(negedge clk);
    check("mid_busy", busy, 1);
    rst_n       = 1'b0;
    cl_lock_req = '0;
    #1;
    check_all_zero("midreset");
    exp_task_q.delete();
    core_res_q.delete();
    model_last = NC - 1;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    acquire(4'b0101, e);
    check("post_reset_owner_id", owner_id, CWT'(e));
    release_all(e);
    repeat (3) tick();

    check("own_q_empty", exp_own_q.size(), 0);
    check("wr_q_empty", exp_wr_q.size(), 0);
    check("task_q_empty", exp_task_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
